// File: rtl/irq_dispatch_pkg.sv
// Shared types and constants for the irq_dispatch block: FSM states, bus codes
// and the per-bus channel count.
package irq_dispatch_pkg;

    localparam int NCHAN = 9;
    localparam int NBUS  = 3;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        PRESENT = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    // One-hot mask selecting a single channel of a bus.
    function automatic logic [NCHAN-1:0] chan_mask(input logic [3:0] chan);
        return NCHAN'(1) << chan;
    endfunction

endpackage

// File: rtl/irq_dispatch_prio_enc9.sv
// 9-bit lowest-index priority encoder with an any-valid flag; one instance
// ranks the eligible channels of one bus.
module prio_enc9 (
    input  logic [8:0] req,
    output logic       any,
    output logic [3:0] idx
);

    assign any = |req;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_dispatch.sv
// Three-bus, nine-channel interrupt dispatcher: latches requests, ranks A > B > C
// and lowest channel first, and presents one winner at a time until acknowledged.
// Optional presentation timeout is built when IRQ_DISPATCH_TIMEOUT_EN is defined.
module irq_dispatch
    import irq_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCHAN-1:0] en,
    input  logic [NCHAN-1:0] req_a,
    input  logic [NCHAN-1:0] req_b,
    input  logic [NCHAN-1:0] req_c,
    input  logic             irq_ack,
    output logic             pa,
    output logic             pb,
    output logic             pc,
    output logic             irq_valid,
    output logic [1:0]       irq_bus,
    output logic [3:0]       irq_chan,
    output logic             timeout
);

    // Handshake: irq_valid is high for the whole PRESENT state with irq_bus and
    // irq_chan frozen; the consumer raises irq_ack for one cycle to retire it.
    // irq_ack outside PRESENT has no effect.

    logic [NCHAN-1:0] pend_a, pend_b, pend_c;
    logic [NCHAN-1:0] elig_a, elig_b, elig_c;
    logic [NCHAN-1:0] clr_a, clr_b, clr_c;
    logic             any_a, any_b, any_c, any_elig;
    logic [3:0]       idx_a, idx_b, idx_c;
    logic [1:0]       win_bus;
    logic [3:0]       win_chan;
    logic [1:0]       sel_bus;
    logic [3:0]       sel_chan;
    logic             capture;
    state_t           state, state_next;

    assign elig_a = pend_a & en;
    assign elig_b = pend_b & en;
    assign elig_c = pend_c & en;

    prio_enc9 u_enc_a (.req(elig_a), .any(any_a), .idx(idx_a));
    prio_enc9 u_enc_b (.req(elig_b), .any(any_b), .idx(idx_b));
    prio_enc9 u_enc_c (.req(elig_c), .any(any_c), .idx(idx_c));

    assign any_elig = any_a | any_b | any_c;

    always_comb begin
        win_bus  = BUS_A;
        win_chan = idx_a;
        if (any_a) begin
            win_bus  = BUS_A;
            win_chan = idx_a;
        end else if (any_b) begin
            win_bus  = BUS_B;
            win_chan = idx_b;
        end else if (any_c) begin
            win_bus  = BUS_C;
            win_chan = idx_c;
        end
    end

    // Only the captured bit is cleared, and only on the edge leaving CLEAR.
    always_comb begin
        clr_a = '0;
        clr_b = '0;
        clr_c = '0;
        if (state == CLEAR) begin
            case (sel_bus)
                BUS_A:   clr_a = chan_mask(sel_chan);
                BUS_B:   clr_b = chan_mask(sel_chan);
                BUS_C:   clr_c = chan_mask(sel_chan);
                default: ;
            endcase
        end
    end

    // A new request ORs in after the clear, so a coincident set is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a <= '0;
            pend_b <= '0;
            pend_c <= '0;
        end else begin
            pend_a <= (pend_a & ~clr_a) | req_a;
            pend_b <= (pend_b & ~clr_b) | req_b;
            pend_c <= (pend_c & ~clr_c) | req_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= 1'b0;
            pb <= 1'b0;
            pc <= 1'b0;
        end else begin
            pa <= any_a;
            pb <= any_b;
            pc <= any_c;
        end
    end

`ifdef IRQ_DISPATCH_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;
    logic       expire;
    logic       timeout_fire;

    assign expire = (cnt == CNT_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
        timeout_fire = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (any_elig) begin
                    capture    = 1'b1;
                    state_next = PRESENT;
                end else begin
                    state_next = IDLE;
                end
            end
            PRESENT: begin
                // An ack on the expiry cycle takes precedence over the timeout.
                if (irq_ack) begin
                    state_next = CLEAR;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
                end else if (expire) begin
                    state_next   = CLEAR;
                    timeout_fire = 1'b1;
`endif
                end
            end
            CLEAR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_bus  <= 2'd0;
            sel_chan <= 4'd0;
        end else if (capture) begin
            sel_bus  <= win_bus;
            sel_chan <= win_chan;
        end
    end

`ifdef IRQ_DISPATCH_TIMEOUT_EN
    // Counts completed PRESENT cycles; restarts on every entry to PRESENT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            timeout <= 1'b0;
        end else begin
            cnt     <= (state == PRESENT && state_next == PRESENT) ? cnt + 8'd1 : 8'd0;
            timeout <= timeout_fire;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign irq_valid = (state == PRESENT);
    assign irq_bus   = sel_bus;
    assign irq_chan  = sel_chan;

endmodule
